// File: rtl/spike_readout_argmax_if.sv
// ----------------------------------------------------------------------------
// spike_readout_argmax_if
// Bundles the host request, the spike-counter interface and the result
// handshake of spike_readout_argmax.
//   start_i        host -> readout   request a new inference window
//   window_len_i   host -> readout   window length in cycles
//   count_i        counters -> readout  packed counts, class k at [k*WIDTH_P +: WIDTH_P]
//   counter_rst_no readout -> counters  active-low synchronous counter clear
//   busy_o         readout -> host   high whenever a window is in progress
//   valid_o/ready_i                  result handshake
//   class_o, max_count_o, tie_o      result payload
// master: host / counter side.  slave: the readout block.
// ----------------------------------------------------------------------------
interface spike_readout_argmax_if #(
    parameter int NUM_CLASSES = 10,
    parameter int WIDTH_P     = 8,
    parameter int WINDOW_W    = 16,
    parameter int IDX_W       = 4
);
    logic                           start_i;
    logic [WINDOW_W-1:0]            window_len_i;
    logic [NUM_CLASSES*WIDTH_P-1:0] count_i;
    logic                           counter_rst_no;
    logic                           busy_o;
    logic                           valid_o;
    logic                           ready_i;
    logic [IDX_W-1:0]               class_o;
    logic [WIDTH_P-1:0]             max_count_o;
    logic                           tie_o;

    modport master (
        output start_i, window_len_i, count_i, ready_i,
        input  counter_rst_no, busy_o, valid_o, class_o, max_count_o, tie_o
    );

    modport slave (
        input  start_i, window_len_i, count_i, ready_i,
        output counter_rst_no, busy_o, valid_o, class_o, max_count_o, tie_o
    );
endinterface

// File: rtl/spike_readout_argmax.sv
// ----------------------------------------------------------------------------
// spike_readout_argmax
// Runs one inference window over the per-neuron spike counters: clears them,
// lets them accumulate for L cycles, snapshots every count and then scans the
// snapshot one class per cycle for the argmax. The winner is offered on a
// valid/ready handshake and held until accepted.
// Ports:
//   clk_i   clock, all state on the rising edge
//   rst_ni  asynchronous active-low reset
//   bus     spike_readout_argmax_if.slave (request, counters, result)
// All outputs are registered.
// ----------------------------------------------------------------------------
module spike_readout_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int WIDTH_P     = 8,
    parameter int WINDOW_W    = 16,
    parameter int IDX_W       = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    spike_readout_argmax_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WINDOW,
        S_SNAP,
        S_SCAN,
        S_DONE
    } state_e;

    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic [WINDOW_W-1:0] WIN_ONE  = WINDOW_W'(1);

    state_e              state_q;
    logic [WINDOW_W-1:0] win_q;
    logic [WIDTH_P-1:0]  snap_q [NUM_CLASSES];
    logic [IDX_W-1:0]    scan_idx_q;

    // Running argmax over the classes scanned so far.
    logic [IDX_W-1:0]    best_idx_q, best_idx_d;
    logic [WIDTH_P-1:0]  best_cnt_q, best_cnt_d;
    logic                tie_q, tie_d;
    logic [WIDTH_P-1:0]  cur_cnt;

    // Registered outputs.
    logic                crst_n_q;
    logic                busy_q;
    logic                valid_q;
    logic [IDX_W-1:0]    class_q;
    logic [WIDTH_P-1:0]  max_cnt_q;
    logic                tie_out_q;

    // One scan step. Strictly-greater replaces the leader, so on equal counts
    // the lowest index stays in front and only the tie flag is raised.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        cur_cnt    = snap_q[scan_idx_q];
        best_idx_d = best_idx_q;
        best_cnt_d = best_cnt_q;
        tie_d      = tie_q;
        if (scan_idx_q == '0) begin
            best_idx_d = '0;
            best_cnt_d = cur_cnt;
            tie_d      = 1'b0;
        end else if (cur_cnt > best_cnt_q) begin
            best_idx_d = scan_idx_q;
            best_cnt_d = cur_cnt;
            tie_d      = 1'b0;
        end else if (cur_cnt == best_cnt_q) begin
            tie_d      = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            win_q      <= '0;
            scan_idx_q <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            tie_q      <= 1'b0;
            crst_n_q   <= 1'b1;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            class_q    <= '0;
            max_cnt_q  <= '0;
            tie_out_q  <= 1'b0;
            // NOTE: the snapshot is only NUM_CLASSES flops, so it is reset too;
            // a reset then leaves no stale counts from an aborted window.
            for (int k = 0; k < NUM_CLASSES; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            // NOTE: all state here uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        state_q  <= S_CLEAR;
                        // A zero length behaves as a one-cycle window.
                        win_q    <= (bus.window_len_i == '0) ? WIN_ONE : bus.window_len_i;
                        crst_n_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    // Counters clear on the edge ending this cycle.
                    crst_n_q <= 1'b1;
                    state_q  <= S_WINDOW;
                end
                S_WINDOW: begin
                    // Down-count from L; stop at 1 so the counter never wraps.
                    if (win_q == WIN_ONE) begin
                        state_q <= S_SNAP;
                    end else begin
                        win_q <= win_q - WIN_ONE;
                    end
                end
                S_SNAP: begin
                    // count_i now holds exactly the L window edges of spikes.
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        snap_q[k] <= bus.count_i[k*WIDTH_P +: WIDTH_P];
                    end
                    scan_idx_q <= '0;
                    state_q    <= S_SCAN;
                end
                S_SCAN: begin
                    best_idx_q <= best_idx_d;
                    best_cnt_q <= best_cnt_d;
                    tie_q      <= tie_d;
                    if (scan_idx_q == LAST_IDX) begin
                        // Result registers take the final step directly so
                        // valid_o and the payload appear together.
                        class_q   <= best_idx_d;
                        max_cnt_q <= best_cnt_d;
                        tie_out_q <= tie_d;
                        valid_q   <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        scan_idx_q <= scan_idx_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    crst_n_q <= 1'b1;
                    busy_q   <= 1'b0;
                    valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.counter_rst_no = crst_n_q;
    assign bus.busy_o         = busy_q;
    assign bus.valid_o        = valid_q;
    assign bus.class_o        = class_q;
    assign bus.max_count_o    = max_cnt_q;
    assign bus.tie_o          = tie_out_q;

endmodule

// File: tb/tb_spike_readout_argmax.sv
// ----------------------------------------------------------------------------
// tb_spike_readout_argmax
// Self-checking bench for spike_readout_argmax. A behavioural model of the
// upstream spike counters feeds count_i; expected results come from summing
// the injected spikes over the window cycles and taking the argmax.
// Directed vectors live in a table; random windows and a mid-scan reset follow.
// ----------------------------------------------------------------------------
module tb_spike_readout_argmax;

    localparam int N    = 10;
    localparam int W    = 8;
    localparam int WW   = 16;
    localparam int IW   = 4;
    localparam int MAXC = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    spike_readout_argmax_if #(.NUM_CLASSES(N), .WIDTH_P(W), .WINDOW_W(WW), .IDX_W(IW)) bus ();

    spike_readout_argmax #(.NUM_CLASSES(N), .WIDTH_P(W), .WINDOW_W(WW), .IDX_W(IW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Spikes applied in cycle c of a transaction (cycle 0 = start sampled).
    logic [N-1:0] spk [MAXC];
    logic [N-1:0] spike_q;
    logic [W-1:0] cnt [N];

    int n_checks = 0;
    int n_err    = 0;

    // Upstream counter model: synchronous clear while counter_rst_no is low.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < N; k++)
                cnt[k] <= bus.counter_rst_no ? cnt[k] + W'(spike_q[k]) : '0;
        end
    end

    always_comb begin
        bus.count_i = '0;
        for (int k = 0; k < N; k++) bus.count_i[k*W +: W] = cnt[k];
    end

    typedef struct {
        int len;
        int kind;
        int hold;
        bit early;
        int e_cls;
        int e_max;
        bit e_tie;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: per-class sum of spikes over window cycles 2..leff+1, modulo
    // 2**W, then the lowest index holding the maximum; tie if it is not unique.
    task automatic model(input int leff, output int cls, output int mx, output bit tie);
        int sums [N];
        int nmax;
        for (int k = 0; k < N; k++) begin
            sums[k] = 0;
            for (int c = 2; c <= leff + 1; c++) sums[k] += int'(spk[c][k]);
            sums[k] = sums[k] % (1 << W);
        end
        mx = 0;
        for (int k = 0; k < N; k++) if (sums[k] > mx) mx = sums[k];
        cls  = -1;
        nmax = 0;
        for (int k = 0; k < N; k++) begin
            if (sums[k] == mx) begin
                nmax++;
                if (cls < 0) cls = k;
            end
        end
        tie = (nmax > 1);
    endtask

    task automatic fill(input int kind);
        for (int c = 0; c < MAXC; c++) spk[c] = '0;
        case (kind)
            0: begin // L=5: class 3 on four window cycles, class 7 on two
                for (int c = 2; c <= 5; c++) spk[c][3] = 1'b1;
                spk[2][7] = 1'b1;
                spk[6][7] = 1'b1;
                spk[7][7] = 1'b1; // SNAP cycle, not counted
                spk[1][3] = 1'b1; // CLEAR cycle, not counted
            end
            1: begin // L=12: classes 2 and 6 both reach 9
                for (int c = 2; c <= 10; c++) spk[c][2] = 1'b1;
                for (int c = 5; c <= 13; c++) spk[c][6] = 1'b1;
                for (int c = 2; c <= 9;  c++) spk[c][0] = 1'b1;
                spk[0][5] = 1'b1;
                spk[1][5] = 1'b1;
                for (int c = 14; c <= 30; c++) spk[c][5] = 1'b1;
            end
            2: begin // L=1: class 0 in the window, class 1 only outside it
                spk[2][0] = 1'b1;
                spk[0][1] = 1'b1;
                spk[1][1] = 1'b1;
                spk[3][1] = 1'b1;
            end
            default: ; // no spikes
        endcase
    endtask

    task automatic fill_random();
        int prob [N];
        for (int k = 0; k < N; k++) prob[k] = $urandom_range(5, 60);
        for (int c = 0; c < MAXC; c++)
            for (int k = 0; k < N; k++)
                spk[c][k] = ($urandom_range(0, 99) < prob[k]);
    endtask

    // Entered and left on a falling edge; the exit point is the first IDLE
    // cycle, so consecutive calls issue start_i back-to-back.
    task automatic run_txn(input int len, input int hold, input bit early,
                           input int e_cls, input int e_max, input bit e_tie,
                           input string tag);
        int leff, exp_valid, c, first_valid, crst_bad, busy_bad, hold_bad, keep_bad;
        leff      = (len == 0) ? 1 : len;
        exp_valid = leff + 3 + N;
        bus.start_i      = 1'b1;
        bus.window_len_i = WW'(len);
        bus.ready_i      = early;
        spike_q          = spk[0];
        c = 0; first_valid = -1; crst_bad = 0; busy_bad = 0;
        while (first_valid < 0 && c < exp_valid + 8) begin
            @(negedge clk);
            c++;
            bus.start_i      = 1'b0;
            bus.window_len_i = WW'($urandom_range(0, 65535));
            if (bus.valid_o === 1'b1) first_valid = c;
            if (bus.counter_rst_no !== (c != 1)) crst_bad++;
            if (bus.busy_o !== 1'b1) busy_bad++;
            spike_q = spk[c % MAXC];
        end
        check({tag, "/valid_cycle"}, first_valid, exp_valid);
        check({tag, "/crst_pulse"}, crst_bad, 0);
        check({tag, "/busy"}, busy_bad, 0);
        check({tag, "/class"}, bus.class_o, e_cls);
        check({tag, "/max"}, bus.max_count_o, e_max);
        check({tag, "/tie"}, bus.tie_o, e_tie);
        if (!early) begin
            hold_bad = 0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (bus.valid_o !== 1'b1 || bus.class_o !== IW'(e_cls) ||
                    bus.max_count_o !== W'(e_max) || bus.tie_o !== e_tie) hold_bad++;
                bus.start_i = 1'b1; // ignored outside IDLE
                spike_q     = N'($urandom);
            end
            @(negedge clk);
            if (bus.valid_o !== 1'b1 || bus.class_o !== IW'(e_cls) ||
                bus.max_count_o !== W'(e_max) || bus.tie_o !== e_tie) hold_bad++;
            check({tag, "/hold_stable"}, hold_bad, 0);
            bus.start_i = 1'b0;
            bus.ready_i = 1'b1;
        end
        @(negedge clk);
        check({tag, "/valid_drop"}, bus.valid_o, 1'b0);
        check({tag, "/idle"}, bus.busy_o, 1'b0);
        keep_bad = (bus.class_o !== IW'(e_cls) || bus.max_count_o !== W'(e_max) ||
                    bus.tie_o !== e_tie) ? 1 : 0;
        check({tag, "/retained"}, keep_bad, 0);
        bus.ready_i = 1'b0;
    endtask

    initial begin
        int e_cls, e_max, len;
        bit e_tie;

        bus.start_i      = 1'b0;
        bus.window_len_i = '0;
        bus.ready_i      = 1'b0;
        spike_q          = '0;

        //            len kind hold early cls max tie
        vecs[0] = '{  5,  0,   0,   0,    3,  4,  0 }; // basic window
        vecs[1] = '{ 12,  1,  20,   0,    2,  9,  1 }; // tie + backpressure, start in DONE
        vecs[2] = '{  1,  2,   0,   1,    0,  1,  0 }; // edge capture, ready early
        vecs[3] = '{  0,  3,   3,   0,    0,  0,  1 }; // zero length, all zero

        #1 rst_n = 1'b0;
        #1;
        check("reset/busy", bus.busy_o, 1'b0);
        check("reset/valid", bus.valid_o, 1'b0);
        check("reset/crst", bus.counter_rst_no, 1'b1);
        check("reset/class", bus.class_o, 0);
        check("reset/max", bus.max_count_o, 0);
        check("reset/tie", bus.tie_o, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            fill(vecs[i].kind);
            run_txn(vecs[i].len, vecs[i].hold, vecs[i].early,
                    vecs[i].e_cls, vecs[i].e_max, vecs[i].e_tie, $sformatf("vec%0d", i));
        end

        for (int r = 0; r < 12; r++) begin
            fill_random();
            len = $urandom_range(0, 40);
            model((len == 0) ? 1 : len, e_cls, e_max, e_tie);
            run_txn(len, $urandom_range(0, 4), 1'(($urandom_range(0, 1))),
                    e_cls, e_max, e_tie, $sformatf("rnd%0d", r));
        end

        // Reset between edges while the scan is in progress.
        fill_random();
        bus.start_i      = 1'b1;
        bus.window_len_i = WW'(3);
        spike_q          = spk[0];
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            spike_q     = spk[c];
        end
        check("midscan/busy_before", bus.busy_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midscan/busy", bus.busy_o, 1'b0);
        check("midscan/valid", bus.valid_o, 1'b0);
        check("midscan/crst", bus.counter_rst_no, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_random();
        len = 7;
        model(len, e_cls, e_max, e_tie);
        run_txn(len, 2, 1'b0, e_cls, e_max, e_tie, "after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
